// File: rtl/reg_file_sb.sv
// Parametrised integer register file with same-cycle write bypass and a
// per-register busy scoreboard that decode uses for hazard stalls.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy1,
    output logic            busy2,
    input  logic            reg_wr,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             wr_en;

    assign wr_en = reg_wr && !((ZERO_REG != 0) && (waddr == '0));

    // NOTE: combinational blocks use blocking assignments and start from a full
    // default, so every path assigns every output and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[waddr] = wdata;
    end

    // Issue outranks a same-cycle writeback: the new producer supersedes the old one.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int r = 0; r < int'(NREGS); r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_valid && (iss_rd == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                busy_d[r] = 1'b1;
            end else if (reg_wr && (waddr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + (AW + 1)'(busy_d[r]);
        end
    end

    // NOTE: the storage array is reset on purpose, since a reset must read back as zero
    // immediately; a file without that need would leave memories unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(NREGS); r++) mem_q[r] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Returns {busy, data} for one read port.
    function automatic logic [XLEN:0] read_port(input logic [AW-1:0] ra);
        logic [XLEN-1:0] data;
        logic            bsy;
        data = mem_q[ra];
        bsy  = busy_q[ra];
        if ((ZERO_REG != 0) && (ra == '0)) begin
            data = '0;
            bsy  = 1'b0;
        end else if ((BYPASS != 0) && reg_wr && (waddr == ra)) begin
            data = wdata;
            if (!(iss_valid && (iss_rd == ra))) bsy = 1'b0;
        end
        return {bsy, data};
    endfunction

    logic [XLEN:0] port1, port2;

    always_comb begin
        port1 = '0;
        port2 = '0;
        if (reset_n) begin
            port1 = read_port(raddr1);
            port2 = read_port(raddr2);
        end
    end

    assign rdata1   = port1[XLEN-1:0];
    assign busy1    = port1[XLEN];
    assign rdata2   = port2[XLEN-1:0];
    assign busy2    = port2[XLEN];
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one instance with x0 hardwired and bypass on,
// one with an ordinary x0 and no bypass, both fed the same directed stimulus.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   raddr1, raddr2, waddr, iss_rd;
    logic [XLEN-1:0] wdata;
    logic            reg_wr, iss_valid, flush;

    logic [XLEN-1:0] rdata1, rdata2, n_rdata1, n_rdata2;
    logic            busy1, busy2, n_busy1, n_busy2;
    logic [AW:0]     busy_cnt, n_busy_cnt;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(n_rdata1), .rdata2(n_rdata2),
        .busy1(n_busy1), .busy2(n_busy2),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(n_busy_cnt)
    );

    typedef enum {S_RD1, S_RD2, S_BZ1, S_BZ2, S_CNT, S_NRD1, S_NBZ1, S_NCNT} sel_e;
    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic expire = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input sel_e s);
        case (s)
            S_RD1:   return rdata1;
            S_RD2:   return rdata2;
            S_BZ1:   return {31'b0, busy1};
            S_BZ2:   return {31'b0, busy2};
            S_CNT:   return 32'(busy_cnt);
            S_NRD1:  return n_rdata1;
            S_NBZ1:  return {31'b0, n_busy1};
            default: return 32'(n_busy_cnt);
        endcase
    endfunction

    // Monitor: outputs are combinational, so every mid-cycle sample is a presentation.
    exp_t        m_t;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && (q[0].cyc <= cyc || expire)) begin
            m_t   = q.pop_front();
            m_act = actual(m_t.sel);
            n_cmp++;
            if (m_t.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: not sampled in its cycle (queued %0d, now %0d)", m_t.name, m_t.cyc, cyc);
            end else if (m_act !== m_t.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", m_t.name, m_act, m_t.exp);
            end
        end
    end

    task automatic e(input sel_e s, input logic [31:0] v, input string n);
        exp_t t;
        t.cyc  = cyc;
        t.sel  = s;
        t.exp  = v;
        t.name = n;
        q.push_back(t);
    endtask

    // Start a new cycle: wait past the edge and drop the single-cycle strobes.
    task automatic tick_in();
        @(posedge clk);
        #1;
        reg_wr    = 1'b0;
        iss_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        reg_wr = 1'b1;
        waddr  = a;
        wdata  = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        iss_valid = 1'b1;
        iss_rd    = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; raddr1 = '0; raddr2 = '0; waddr = '0; iss_rd = '0;
        wdata = '0; reg_wr = 1'b0; iss_valid = 1'b0; flush = 1'b0;

        // Held in reset: nothing visible, nothing taken.
        tick_in(); raddr1 = 5; wr(5, 32'h1234); iss(5);
        e(S_RD1, 0, "rst_rdata"); e(S_BZ1, 0, "rst_busy"); e(S_CNT, 0, "rst_cnt");
        tick_in(); reset_n = 1'b1;
        e(S_RD1, 0, "rst_no_write");

        // Reset mid-run.
        tick_in(); wr(5, 32'hDEADBEEF);
        tick_in(); iss(7); raddr1 = 5;
        e(S_RD1, 32'hDEADBEEF, "x5_read"); e(S_NRD1, 32'hDEADBEEF, "nb_x5_read");
        tick_in(); raddr2 = 7;
        e(S_BZ2, 1, "x7_busy"); e(S_CNT, 1, "x7_cnt");
        tick_in(); reset_n = 1'b0;
        e(S_RD1, 0, "midrst_rdata"); e(S_BZ2, 0, "midrst_busy"); e(S_CNT, 0, "midrst_cnt");
        e(S_NCNT, 0, "nb_midrst_cnt");
        @(negedge clk); #1; reset_n = 1'b1;
        tick_in();
        e(S_RD1, 0, "midrst_cleared"); e(S_CNT, 0, "midrst_cnt_after");

        // x0 handling.
        tick_in(); wr(0, 32'hFFFFFFFF); iss(0); raddr1 = 0; raddr2 = 0;
        e(S_RD1, 0, "x0_same_cycle"); e(S_BZ1, 0, "x0_busy_same"); e(S_NRD1, 0, "nb_x0_no_bypass");
        tick_in();
        e(S_RD1, 0, "x0_reads0"); e(S_BZ1, 0, "x0_not_busy"); e(S_CNT, 0, "x0_cnt");
        e(S_NRD1, 32'hFFFFFFFF, "nb_x0_written"); e(S_NBZ1, 1, "nb_x0_busy"); e(S_NCNT, 1, "nb_x0_cnt");
        tick_in(); flush = 1'b1;

        // Bypass.
        tick_in(); wr(3, 32'h11);
        tick_in(); wr(3, 32'h22); raddr1 = 3; raddr2 = 3;
        e(S_RD1, 32'h22, "byp_rd1"); e(S_RD2, 32'h22, "byp_rd2"); e(S_NRD1, 32'h11, "nb_old_value");
        tick_in();
        e(S_RD1, 32'h22, "byp_stored"); e(S_NRD1, 32'h22, "nb_stored"); e(S_NCNT, 0, "nb_flushed");

        // Scoreboard lifecycle.
        tick_in(); iss(4);
        tick_in(); iss(9); raddr1 = 4;
        e(S_CNT, 1, "sb_cnt1"); e(S_BZ1, 1, "sb_x4_busy");
        tick_in(); wr(4, 32'h44); raddr2 = 9;
        e(S_CNT, 2, "sb_cnt2"); e(S_BZ1, 0, "sb_x4_wb_unstall"); e(S_BZ2, 1, "sb_x9_busy");
        e(S_RD1, 32'h44, "sb_x4_bypass"); e(S_NBZ1, 1, "nb_x4_still_busy");
        tick_in();
        e(S_CNT, 1, "sb_cnt_after_wb"); e(S_BZ1, 0, "sb_x4_clear");
        tick_in(); wr(9, 32'h99);
        tick_in(); e(S_CNT, 0, "sb_cnt0");
        tick_in(); wr(9, 32'h999); e(S_CNT, 0, "wb_idle_cnt");
        tick_in();
        e(S_RD2, 32'h999, "wb_idle_data"); e(S_BZ2, 0, "wb_idle_busy"); e(S_CNT, 0, "wb_idle_cnt_after");

        // Collision and independent issue/writeback.
        tick_in(); iss(6);
        tick_in(); iss(6); wr(6, 32'h55); raddr1 = 6;
        e(S_BZ1, 1, "col_busy"); e(S_CNT, 1, "col_cnt"); e(S_RD1, 32'h55, "col_bypass");
        tick_in();
        e(S_BZ1, 1, "col_still_busy"); e(S_CNT, 1, "col_cnt_after"); e(S_RD1, 32'h55, "col_stored");
        tick_in(); iss(10); wr(6, 32'h66);
        e(S_CNT, 1, "diff_cnt");
        tick_in(); raddr1 = 10; raddr2 = 6;
        e(S_CNT, 1, "diff_cnt_after"); e(S_BZ1, 1, "diff_x10_busy"); e(S_BZ2, 0, "diff_x6_free");
        e(S_RD2, 32'h66, "diff_x6_data");
        tick_in(); wr(10, 32'hA);
        tick_in(); e(S_CNT, 0, "diff_cnt0");

        // Flush drops a same-cycle issue.
        tick_in(); iss(1);
        tick_in(); iss(2);
        tick_in(); iss(31);
        tick_in(); flush = 1'b1; iss(8); raddr1 = 8;
        e(S_CNT, 3, "fl_cnt3");
        tick_in(); raddr2 = 31;
        e(S_CNT, 0, "fl_cnt0"); e(S_BZ1, 0, "fl_x8_dropped"); e(S_BZ2, 0, "fl_x31_clear");
        e(S_NCNT, 0, "nb_fl_cnt0");

        // Fill every register: 31 writable on the main instance, 32 on the other.
        for (int r = 0; r < 32; r++) begin
            tick_in(); iss(AW'(r));
            e(S_CNT, (r == 0) ? 0 : r - 1, "fill_cnt");
            e(S_NCNT, r, "nb_fill_cnt");
        end
        tick_in(); raddr1 = 0; raddr2 = 31;
        e(S_CNT, 31, "fill_cnt31"); e(S_NCNT, 32, "nb_fill_cnt32");
        e(S_BZ1, 0, "fill_x0_free"); e(S_NBZ1, 1, "nb_fill_x0_busy"); e(S_BZ2, 1, "fill_x31_busy");
        tick_in(); flush = 1'b1;
        tick_in();
        e(S_CNT, 0, "final_cnt0"); e(S_NCNT, 0, "nb_final_cnt0");

        // Let the monitor drain; anything left after the budget is flushed as a failure.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            expire = 1'b1;
            @(posedge clk);
            @(posedge clk);
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline integer register file. Width, depth and x0 handling are configurable.
- Adds same-cycle write-to-read bypass, so there is no separate WB→ID forwarding mux.
- Adds a per-register busy scoreboard with an outstanding-writer counter and a flush, used by the decode stage for load-use and long-latency hazard stalls.
- Sits between decode (reads, issue) and writeback (write) in the pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREGS), address width (derived; do not override).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return the stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- raddr1  in  AW  read address, port 1
- raddr2  in  AW  read address, port 2
- rdata1  out  XLEN  read data, port 1 (combinational)
- rdata2  out  XLEN  read data, port 2 (combinational)
- busy1  out  1  register at raddr1 has an outstanding writer (combinational)
- busy2  out  1  register at raddr2 has an outstanding writer (combinational)
- reg_wr  in  1  write enable (writeback)
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- iss_valid  in  1  an instruction with a destination is issuing this cycle
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  pipeline flush; clears every busy bit
- busy_cnt  out  AW+1  number of currently set busy bits (registered)

Behaviour:
- Reset: asserting reset_n=0 immediately clears all registers, all busy bits and busy_cnt; this takes effect mid-operation too. While reset_n=0, rdata*/busy* read 0 and no write or issue is taken.
- Storage write: on a rising edge with reg_wr=1, mem[waddr] <= wdata. The write is ignored when ZERO_REG=1 and waddr=0.
- Reads:
  - When ZERO_REG=1 and raddr=0, rdataN=0 and busyN=0.
  - Else, when BYPASS=1, reg_wr=1 and waddr=raddrN, rdataN=wdata this cycle.
  - Else rdataN=mem[raddrN].
  - Both ports resolve independently and may use the same address.
- Scoreboard, next state of busy[r] per edge, in priority order:
  1. flush=1 → 0, for all r; any issue that cycle is dropped.
  2. iss_valid=1 and iss_rd=r (excluding r=0 when ZERO_REG=1) → 1. Issue wins over a same-cycle writeback to r, because the new producer supersedes the old one.
  3. reg_wr=1 and waddr=r → 0.
  4. Otherwise hold.
- Issue to an already-busy register keeps it at 1; there is no counting per register.
- Writeback to a non-busy register still writes data and leaves busy at 0.
- busyN output: busy[raddrN], except it is forced to 0 when BYPASS=1, reg_wr=1, waddr=raddrN and the register is not also being re-issued that cycle. The value is then available via bypass, so decode must not stall.
- busy_cnt:
  - Registered population count of busy[], updated every edge to match the next-state vector (one-cycle latency relative to the causing event).
  - Range 0..NREGS, hence AW+1 bits; it never wraps.
  - flush sets it to 0 at the next edge.
- Simultaneous issue and writeback to different registers: both apply, so busy_cnt is unchanged.

Test Plan:
- Reset mid-run: write x5=0xDEADBEEF, issue x7, then pulse reset_n=0 between edges → rdata for x5 is 0 immediately; busy_cnt=0; busy for x7=0.
- x0 handling (ZERO_REG=1): reg_wr, waddr=0, wdata=0xFFFFFFFF, plus iss_valid with iss_rd=0 → reading address 0 gives 0; busy=0; busy_cnt stays 0.
- Bypass: x3 holds 0x11; in the same cycle reg_wr, waddr=3, wdata=0x22 with raddr1=raddr2=3 → both rdata=0x22 that cycle, 0x22 after the edge. With BYPASS=0 the same-cycle read returns 0x11.
- Scoreboard lifecycle:
  - Issue x4, x9 on consecutive cycles → busy_cnt 1 then 2; busy for x4 reads 1.
  - Writeback x4 → busy_cnt=1 after the edge, and busy for x4 already reads 0 during the writeback cycle.
- Collision: x6 busy; in the same cycle iss_valid with iss_rd=6 and reg_wr with waddr=6, wdata=0x55 → x6 stays busy, busy6=1 that cycle, mem[6]=0x55, busy_cnt unchanged.
- Flush: busy set on x1, x2, x31 (busy_cnt=3); flush together with iss_valid, iss_rd=8 → all busy=0 and busy_cnt=0 after the edge; x8 is not busy. Filling all 31 writable registers gives busy_cnt=31 with no wrap.
